// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, frame-loader state encoding and the
// bit-reverse index helper used by the loader and any bit-reversing reader.
package fft_pkg;

  localparam int unsigned FFT_N_POINTS = 64;
  localparam int unsigned FFT_LOG2_N   = 6;
  localparam int unsigned FFT_DATA_W   = 16;

  typedef enum logic [2:0] {
    FILL  = 3'd0,
    PAD   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } loader_state_t;

  // Reverses the FFT_LOG2_N LSBs of k.
  function automatic logic [FFT_LOG2_N-1:0] bitrev(input logic [FFT_LOG2_N-1:0] k);
    logic [FFT_LOG2_N-1:0] r;
    r = '0;
    for (int i = 0; i < int'(FFT_LOG2_N); i++) begin
      r[i] = k[int'(FFT_LOG2_N) - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_compute_timer.sv
// Loadable down-counter that flags when the butterfly core's fixed compute time
// has elapsed; updates on the falling edge like the core.
module fft_compute_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;
  logic         done_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // done tracks count==0 one-for-one with the count register.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      done_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      done_q  <= (count_d == '0);
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/fft_sample_loader.sv
// Streams complex samples into a bit-reversed parallel frame buffer, kicks the
// butterfly core and waits out its compute time. Define FFT_LOADER_PRESCALE_EN to
// arithmetic-shift each sample right by PRESCALE_SH before storage.
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS       = FFT_N_POINTS,
  parameter int unsigned LOG2_N         = FFT_LOG2_N,
  parameter int unsigned DATA_W         = FFT_DATA_W,
  parameter int unsigned COMPUTE_CYCLES = 192,
  parameter int unsigned PRESCALE_SH    = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_re,
  input  logic [DATA_W-1:0]          s_im,
  input  logic                       s_last,
  output logic [N_POINTS*DATA_W-1:0] fft_re,
  output logic [N_POINTS*DATA_W-1:0] fft_im,
  output logic                       fft_start,
  output logic                       result_valid,
  output logic                       busy,
  output logic                       frame_err
);

  localparam int unsigned TMR_W = $clog2(COMPUTE_CYCLES);
`ifdef FFT_LOADER_PRESCALE_EN
  localparam bit PRESCALE_EN = 1'b1;
`else
  localparam bit PRESCALE_EN = 1'b0;
`endif
  localparam int unsigned SHIFT = PRESCALE_EN ? PRESCALE_SH : 0;
  localparam logic [LOG2_N-1:0] IDX_LAST = LOG2_N'(N_POINTS - 1);

  loader_state_t     state_q, state_d;
  logic [LOG2_N-1:0] idx_q, idx_d;
  logic              s_ready_q, fft_start_q, result_valid_q, busy_q;
  logic              frame_err_q, frame_err_d;

  logic              beat_c, wr_en_c;
  logic [LOG2_N-1:0] wr_addr_c;
  logic [DATA_W-1:0] samp_re_c, samp_im_c, wr_re_c, wr_im_c;
  logic              tmr_load_c, tmr_en_c, tmr_done;

  logic [DATA_W-1:0] buf_re_q [N_POINTS];
  logic [DATA_W-1:0] buf_im_q [N_POINTS];

  // Arithmetic shift keeps the sign and truncates toward -inf; SHIFT is 0 when disabled.
  assign samp_re_c = DATA_W'($signed(s_re) >>> SHIFT);
  assign samp_im_c = DATA_W'($signed(s_im) >>> SHIFT);

  assign beat_c    = s_valid & s_ready_q;
  assign wr_addr_c = LOG2_N'(bitrev(FFT_LOG2_N'(idx_q)));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_err_d = frame_err_q;
    wr_en_c     = 1'b0;
    wr_re_c     = samp_re_c;
    wr_im_c     = samp_im_c;
    tmr_load_c  = 1'b0;
    tmr_en_c    = 1'b0;
    case (state_q)
      FILL: begin
        if (beat_c) begin
          wr_en_c = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = START;
            idx_d   = '0;
            if (!s_last) frame_err_d = 1'b1;
          end else begin
            idx_d = idx_q + LOG2_N'(1);
            if (s_last) begin
              frame_err_d = 1'b1;
              state_d     = PAD;
            end
          end
        end
      end
      // Short frame: zero-fill the remaining bins one per cycle.
      PAD: begin
        wr_en_c = 1'b1;
        wr_re_c = '0;
        wr_im_c = '0;
        if (idx_q == IDX_LAST) begin
          state_d = START;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + LOG2_N'(1);
        end
      end
      START: begin
        idx_d      = '0;
        tmr_load_c = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (tmr_done) state_d = DONE;
        else          tmr_en_c = 1'b1;
      end
      DONE: begin
        state_d = FILL;
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= FILL;
      idx_q          <= '0;
      s_ready_q      <= 1'b0;
      fft_start_q    <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      s_ready_q      <= (state_d == FILL);
      fft_start_q    <= (state_d == START);
      result_valid_q <= (state_d == DONE);
      busy_q         <= (state_d == START) || (state_d == WAIT) || (state_d == DONE);
      frame_err_q    <= frame_err_d;
    end
  end

  // Frame buffer; only FILL and PAD write, so it is frozen from START to DONE.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(N_POINTS); i++) begin
        buf_re_q[i] <= '0;
        buf_im_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      buf_re_q[wr_addr_c] <= wr_re_c;
      buf_im_q[wr_addr_c] <= wr_im_c;
    end
  end

  fft_compute_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load_c),
    .load_val_i (TMR_W'(COMPUTE_CYCLES - 1)),
    .en_i       (tmr_en_c),
    .done_o     (tmr_done)
  );

  for (genvar g = 0; g < int'(N_POINTS); g++) begin : g_flat
    assign fft_re[g*DATA_W +: DATA_W] = buf_re_q[g];
    assign fft_im[g*DATA_W +: DATA_W] = buf_im_q[g];
  end

  assign s_ready      = s_ready_q;
  assign fft_start    = fft_start_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Randomized bench for fft_sample_loader, checked against a frame-level model
// (bins filled by reversed index, zero padding, sticky length error, fixed latencies).
module tb_fft_sample_loader;

  localparam int N  = 64;
  localparam int DW = 16;
  localparam int CC = 192;

  logic                clk = 1'b0;
  logic                rst;
  logic                s_valid, s_ready, s_last;
  logic [DW-1:0]       s_re, s_im;
  logic [N*DW-1:0]     fft_re, fft_im;
  logic                fft_start, result_valid, busy, frame_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] sre [N];
  logic [DW-1:0] sim [N];
  logic [DW-1:0] m_re [N];
  logic [DW-1:0] m_im [N];
  bit            m_err;

  fft_sample_loader dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_re         (s_re),
    .s_im         (s_im),
    .s_last       (s_last),
    .fft_re       (fft_re),
    .fft_im       (fft_im),
    .fft_start    (fft_start),
    .result_valid (result_valid),
    .busy         (busy),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Bin that sample k lands in: its index read with the 6 bits in reverse order.
  function automatic int rev6(input int k);
    int r;
    r = 0;
    for (int i = 0; i < 6; i++) begin
      r = r * 2 + (k % 2);
      k = k / 2;
    end
    return r;
  endfunction

  // Value the loader stores for an input sample.
  function automatic logic [DW-1:0] stored(input logic [DW-1:0] v);
`ifdef FFT_LOADER_PRESCALE_EN
    int s;
    int q;
    s = int'($signed(v));
    q = s / 64;
    if ((s % 64 != 0) && (s < 0)) q = q - 1;
    return DW'(q);
`else
    return v;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_re[i] = '0;
      m_im[i] = '0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_frame(input int beats, input int last_idx);
    for (int k = 0; k < N; k++) begin
      if (k < beats) begin
        m_re[rev6(k)] = stored(sre[k]);
        m_im[rev6(k)] = stored(sim[k]);
      end else begin
        m_re[rev6(k)] = '0;
        m_im[rev6(k)] = '0;
      end
    end
    if (last_idx != N - 1) m_err = 1'b1;
  endtask

  task automatic check_buffer(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s re[%0d]", tag, i), 32'(fft_re[i*DW +: DW]), 32'(m_re[i]));
      chk($sformatf("%s im[%0d]", tag, i), 32'(fft_im[i*DW +: DW]), 32'(m_im[i]));
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      sre[k] = DW'($urandom);
      sim[k] = DW'($urandom);
    end
  endtask

  // Streams one frame (last_idx<0: no s_last), then follows it through START/WAIT/DONE.
  // abort_lat>0 asserts reset that many cycles after fft_start.
  task automatic run_frame(input string tag, input int last_idx, input bit rand_valid,
                           input int abort_lat);
    int n_offer, exp_d, k, cyc, d, lat, starts, ready_bad, busy_bad;
    n_offer = (last_idx < 0) ? N : last_idx + 1;
    exp_d   = 1 + (N - n_offer);
    k = 0; cyc = 0; ready_bad = 0;
    while (k < n_offer && cyc < 4000) begin
      @(negedge clk); #1;
      s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      s_re    = sre[k];
      s_im    = sim[k];
      s_last  = (k == last_idx);
      @(posedge clk);
      cyc++;
      if (!s_ready) ready_bad++;
      if (s_valid && s_ready) k++;
    end
    chk($sformatf("%s beats", tag), 32'(k), 32'(n_offer));
    chk($sformatf("%s ready_in_fill", tag), 32'(ready_bad), 32'd0);
    model_frame(n_offer, last_idx);

    d = 0; ready_bad = 0;
    do begin
      @(negedge clk); #1;
      s_valid = 1'b1;
      s_last  = 1'b0;
      s_re    = DW'($urandom);
      s_im    = DW'($urandom);
      @(posedge clk);
      d++;
      if (s_ready) ready_bad++;
    end while (!fft_start && d < 300);
    chk($sformatf("%s start_delay", tag), 32'(d), 32'(exp_d));
    chk($sformatf("%s busy_at_start", tag), 32'(busy), 32'd1);

    lat = 0; starts = 0; busy_bad = 0;
    do begin
      @(negedge clk); #1;
      s_re = DW'($urandom);
      @(posedge clk);
      lat++;
      if (s_ready) ready_bad++;
      if (!busy) busy_bad++;
      if (fft_start) starts++;
      if (lat == abort_lat) begin
        chk($sformatf("%s err_before_reset", tag), 32'(frame_err), 32'(m_err));
        rst = 1'b0;
        #1;
        model_clear();
        chk($sformatf("%s rst busy", tag), 32'(busy), 32'd0);
        chk($sformatf("%s rst frame_err", tag), 32'(frame_err), 32'd0);
        chk($sformatf("%s rst result_valid", tag), 32'(result_valid), 32'd0);
        chk($sformatf("%s rst s_ready", tag), 32'(s_ready), 32'd0);
        check_buffer($sformatf("%s rst", tag));
        s_valid = 1'b0;
        return;
      end
    end while (!result_valid && lat < 400);
    chk($sformatf("%s compute_latency", tag), 32'(lat), 32'(CC + 1));
    chk($sformatf("%s extra_start", tag), 32'(starts), 32'd0);
    chk($sformatf("%s ready_while_busy", tag), 32'(ready_bad), 32'd0);
    chk($sformatf("%s busy_drop", tag), 32'(busy_bad), 32'd0);

    @(negedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk);
    chk($sformatf("%s ready_after_done", tag), 32'(s_ready), 32'd1);
    chk($sformatf("%s busy_after_done", tag), 32'(busy), 32'd0);
    chk($sformatf("%s rv_one_cycle", tag), 32'(result_valid), 32'd0);
    chk($sformatf("%s frame_err", tag), 32'(frame_err), 32'(m_err));
    check_buffer(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); #1;
    rst = 1'b0;
    s_valid = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    chk($sformatf("%s ready_in_reset", tag), 32'(s_ready), 32'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    chk($sformatf("%s ready_first_cycle", tag), 32'(s_ready), 32'd0);
    @(posedge clk);
    chk($sformatf("%s ready_after_reset", tag), 32'(s_ready), 32'd1);
  endtask

  initial begin
    int rv_seen, fs_seen;
    s_valid = 1'b0; s_last = 1'b0; s_re = '0; s_im = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    chk("reset s_ready", 32'(s_ready), 32'd0);
    chk("reset fft_start", 32'(fft_start), 32'd0);
    chk("reset result_valid", 32'(result_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset frame_err", 32'(frame_err), 32'd0);
    check_buffer("reset");
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    chk("ready_first_cycle", 32'(s_ready), 32'd0);
    @(posedge clk);
    chk("ready_after_reset", 32'(s_ready), 32'd1);

    // Ramp frame: re=k, im=-k.
    for (int k = 0; k < N; k++) begin
      sre[k] = DW'(k);
      sim[k] = DW'(-k);
    end
    run_frame("ramp", N - 1, 1'b0, 0);
    chk("ramp re[32]", 32'(fft_re[32*DW +: DW]), 32'(stored(DW'(1))));
    chk("ramp re[1]", 32'(fft_re[1*DW +: DW]), 32'(stored(DW'(32))));

    // Random data with 50% valid, plus prescale corner values.
    fill_random();
    sre[0] = 16'h8000;
    sre[1] = 16'h0040;
    run_frame("randvalid", N - 1, 1'b1, 0);
`ifdef FFT_LOADER_PRESCALE_EN
    chk("prescale 8000", 32'(fft_re[0 +: DW]), 32'h0000FE00);
    chk("prescale 0040", 32'(fft_re[32*DW +: DW]), 32'h00000001);
`else
    chk("raw 8000", 32'(fft_re[0 +: DW]), 32'h00008000);
    chk("raw 0040", 32'(fft_re[32*DW +: DW]), 32'h00000040);
`endif

    // Short frame ending at sample 9: zero padding and frame_err.
    fill_random();
    run_frame("short", 9, 1'b0, 0);

    // Long frame without s_last: error, no extra beats consumed.
    do_reset("rst1");
    fill_random();
    run_frame("long", -1, 1'b1, 0);

    // Reset 100 cycles into WAIT discards everything.
    fill_random();
    run_frame("abort", N - 1, 1'b0, 100);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    rv_seen = 0; fs_seen = 0;
    repeat (250) begin
      @(posedge clk);
      if (result_valid) rv_seen++;
      if (fft_start) fs_seen++;
    end
    chk("abort no_result_valid", 32'(rv_seen), 32'd0);
    chk("abort no_fft_start", 32'(fs_seen), 32'd0);
    chk("abort ready_idle", 32'(s_ready), 32'd1);

    fill_random();
    run_frame("after_abort", N - 1, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_sample_loader.md
Name: fft_sample_loader

Overview:
- Front end of the 64-point FFT datapath.
- Accepts complex samples one per beat on a valid/ready stream and writes each one into a parallel frame buffer at its bit-reversed index.
- When the frame is complete, issues a one-cycle start pulse to the butterfly engine and waits out the engine's fixed compute time. It then signals that results are valid and reopens for the next frame.
- It is the writer feeding the in-place butterfly core's parallel input array.

Parameters:
- N_POINTS, 64, frame length; must be a power of two.
- LOG2_N, 6, log2(N_POINTS); also the width of the index counter.
- DATA_W, 16, width of each real/imag sample.
- COMPUTE_CYCLES, 192, cycles from fft_start until core output is valid (LOG2_N * N_POINTS/2).
- PRESCALE_SH, 6, arithmetic right shift applied when FFT_LOADER_PRESCALE_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the falling edge, matching the butterfly core.
- rst  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input sample valid.
- s_ready  out  1  loader can accept a sample.
- s_re  in  DATA_W  sample real part, two's complement.
- s_im  in  DATA_W  sample imag part, two's complement.
- s_last  in  1  marks the final sample of a frame.
- fft_re  out  DATA_W x N_POINTS  bit-reversed frame buffer, real; drives the core's input_Re.
- fft_im  out  DATA_W x N_POINTS  bit-reversed frame buffer, imag; drives the core's input_Im.
- fft_start  out  1  one-cycle start pulse to the core.
- result_valid  out  1  one-cycle pulse when core output is valid.
- busy  out  1  high from fft_start through result_valid.
- frame_err  out  1  sticky; set on a frame-length mismatch, cleared only by reset.

Behaviour:
- Reset values: all buffer entries 0, s_ready 0, fft_start 0, result_valid 0, busy 0, frame_err 0, state FILL, index 0. Reset mid-frame or mid-compute discards everything and returns to this state.
- States: FILL, PAD, START, WAIT, DONE.
- FILL:
  - s_ready=1 (registered; goes high on the first edge after reset release).
  - A beat is a falling edge with s_valid & s_ready. Each beat writes the sample to buffer[bitrev(idx)], then idx increments.
  - idx==N-1 and s_last=1 on the beat: go to START.
  - idx==N-1 and s_last=0: set frame_err, go to START. The stream source must drop its remaining samples; the loader does not consume them.
  - s_last=1 with idx<N-1: set frame_err, go to PAD.
- PAD:
  - s_ready=0.
  - Writes 0+0j to buffer[bitrev(idx)] for each remaining idx, one per cycle, through idx==N-1, then goes to START.
- START:
  - fft_start=1 for exactly one cycle; busy=1; idx cleared.
  - Buffer is frozen from START until leaving DONE.
- WAIT:
  - Down-counter loaded with COMPUTE_CYCLES-1; decrements each cycle.
  - At 0, go to DONE.
- DONE:
  - result_valid=1 for one cycle, busy=1.
  - Next cycle returns to FILL with busy=0 and s_ready=1.
  - Buffer contents persist until overwritten.
- Latency: final accepted beat -> fft_start on the next cycle. fft_start -> result_valid is exactly COMPUTE_CYCLES+1 cycles.
- s_ready is never high in PAD, START, WAIT or DONE. s_valid during those states is ignored and not consumed.
- bitrev(k) reverses the LOG2_N LSBs of k; it is a pure function of idx.
- The index counter wraps only via the state transitions; it never increments past N-1.

Optional Feature:
- FFT_LOADER_PRESCALE_EN defined: each sample's re and im are arithmetic-shifted right by PRESCALE_SH before storage (sign preserved, truncation toward -inf), to bound growth through the unsigned-width core.
- Not defined: samples are stored unmodified. No other behaviour changes.

Decomposition:
- Shared package fft_pkg holds:
  - N_POINTS, LOG2_N, DATA_W defaults;
  - state enum loader_state_t {FILL, PAD, START, WAIT, DONE};
  - function bitrev (LOG2_N-bit reverse), which a future bit-reversing output reader also uses.
- One natural sub-module, fft_compute_timer: loadable down-counter with a done flag, used for WAIT.
- The frame buffer and FSM stay in the top module.

Test Plan:
- Stream 64 samples with s_re=k, s_im=-k, s_last on k=63 -> fft_re[bitrev(k)]=k for all k (e.g. fft_re[32]=1, fft_re[1]=32); fft_start pulses on the cycle after beat 63; frame_err=0.
- Same frame with s_valid toggled 50% randomly -> identical buffer contents; s_ready never drops in FILL; exactly 64 beats consumed.
- s_last at k=9 -> frame_err=1; fft_re[bitrev(k)]=0 for k=10..63; fft_start occurs 54 cycles after the last beat (PAD) plus 1.
- Count from fft_start -> result_valid=1 exactly 193 cycles later; s_ready=0 with s_valid=1 held throughout, no extra beats consumed; s_ready=1 one cycle after result_valid.
- Assert rst low mid-WAIT (cycle 100) -> all buffers 0, busy=0, frame_err=0, no result_valid; a new full frame then loads correctly.
- With FFT_LOADER_PRESCALE_EN: s_re=16'h8000 -> stored 16'hFE00; s_re=16'h0040 -> 16'h0001.
